// File: rtl/adder_pkg.sv
// adder_pkg: mode encoding and parameter check shared by the pipelined adder
package adder_pkg;
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;
  function automatic bit width_ok(input int width, input int seg);
    return seg > 0 && width >= seg && width % seg == 0;
  endfunction
endpackage

// File: rtl/adder_segment.sv
// adder_segment: SEG-bit combinational ripple adder exposing the carry into its MSB
module adder_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o,
  output logic           cmsb_o
);
  logic c;
  always_comb begin
    c = cin_i;
    cmsb_o = cin_i;
    sum_o = '0;
    for (int i = 0; i < SEG; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      cmsb_o = c;
      c = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
  end
  assign cout_o = c;
endmodule

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: add/subtract with one SEG-bit ripple segment per stage and valid/ready flow control
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NSEG = WIDTH / SEG;
  if (!width_ok(WIDTH, SEG)) begin : g_bad
    $error("WIDTH must be a positive multiple of SEG");
  end
  logic [NSEG-1:0] v_all, ld;
  logic o_q;
  for (genvar k = 0; k < NSEG; k++) begin : g_st
    localparam int LO = k * SEG;
    localparam int HI = LO + SEG;
    logic [WIDTH-LO-1:0] a_x, b_x;
    logic [HI-1:0]       s_d, s_q;
    logic [SEG-1:0]      ss;
    logic                c_x, v_x, v_q, c_q, co, cm;
    adder_segment #(.SEG(SEG)) u_seg (
      .a_i   (a_x[SEG-1:0]),
      .b_i   (b_x[SEG-1:0]),
      .cin_i (c_x),
      .sum_o (ss),
      .cout_o(co),
      .cmsb_o(cm)
    );
    if (k == 0) begin : g_in
      // subtraction folds into a + ~b + 1 before the first segment
      assign a_x = a;
      assign b_x = sub == ADD ? b : ~b;
      assign c_x = sub == ADD ? cin : 1'b1;
      assign v_x = in_valid;
      assign s_d = ss;
    end else begin : g_mid
      assign a_x = g_st[k-1].g_op.a_q;
      assign b_x = g_st[k-1].g_op.b_q;
      assign c_x = g_st[k-1].c_q;
      assign v_x = g_st[k-1].v_q;
      assign s_d = {ss, g_st[k-1].s_q};
    end
    if (k < NSEG - 1) begin : g_op
      logic [WIDTH-HI-1:0] a_q, b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld[k]) begin
          a_q <= a_x[WIDTH-LO-1:SEG];
          b_q <= b_x[WIDTH-LO-1:SEG];
        end
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (ld[k]) begin
        v_q <= v_x;
        s_q <= s_d;
        c_q <= co;
      end
    end
    assign v_all[k] = v_q;
    // a stage may load unless it and every stage after it are full and stalled
    assign ld[k] = out_ready || !(&v_all[NSEG-1:k]);
  end
  always_ff @(posedge clk) begin
    if (rst) o_q <= 1'b0;
    else if (ld[NSEG-1]) o_q <= g_st[NSEG-1].cm ^ g_st[NSEG-1].co;
  end
  assign in_ready  = !rst && ld[0];
  assign out_valid = v_all[NSEG-1];
  assign sum       = g_st[NSEG-1].s_q;
  assign cout      = g_st[NSEG-1].c_q;
  assign ovf       = o_q;
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb_pipelined_ripple_adder: directed checks of latency, flags, backpressure, reset flush plus a scoreboarded soak
module tb_pipelined_ripple_adder;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  logic [17:0] res;
  int          vecs = 0, errs = 0;
  logic [15:0] va[8], vb[8];
  logic        vc[8], vs[8];
  logic [17:0] ve[8];
  logic [17:0] q[$];
  pipelined_ripple_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  assign res = {ovf, cout, sum};
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic set_vec(input int i);
    a = va[i];
    b = vb[i];
    cin = vc[i];
    sub = vs[i];
  endtask
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts);
    a = ta;
    b = tb;
    cin = tc;
    sub = ts;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
    logic [15:0] yy;
    logic [16:0] t;
    yy = s ? ~y : y;
    t = {1'b0, x} + {1'b0, yy} + 17'(s ? 1'b1 : c);
    return {(x[15] == yy[15]) && (t[15] != x[15]), t};
  endfunction
  initial begin
    int lat, idx, first, last, extra, p, n, sent, got;
    logic acc, con;
    va = '{16'h0001, 16'h00FF, 16'h0FFF, 16'h8000, 16'h1234, 16'h8000, 16'hAAAA, 16'h1111};
    vb = '{16'h0002, 16'h0001, 16'h0001, 16'h8000, 16'h0234, 16'h0001, 16'h5555, 16'h2222};
    vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ve = '{18'h00003, 18'h00100, 18'h01000, 18'h30000, 18'h11000, 18'h37FFF, 18'h10000, 18'h03334};
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_during_rst", 18'(in_ready), 18'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 18'(out_valid), 18'd0);
    chk("rst_in_ready", 18'(in_ready), 18'd1);
    chk("rst_result", res, 18'h00000);
    send(16'h1234, 16'h1111, 1'b1, 1'b0);
    wait_out(lat);
    chk("latency", 18'(lat), 18'd3);
    chk("add_cin", res, 18'h02346);
    @(posedge clk); #1;
    chk("consumed", 18'(out_valid), 18'd0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_out(lat);
    chk("add_ovf", res, 18'h28000);
    @(posedge clk); #1;
    send(16'h0000, 16'h0001, 1'b0, 1'b1);
    wait_out(lat);
    chk("sub_borrow", res, 18'h0FFFF);
    @(posedge clk); #1;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_out(lat);
    chk("add_wrap", res, 18'h10000);
    @(posedge clk); #1;
    send(16'h0005, 16'h0003, 1'b0, 1'b1);
    wait_out(lat);
    chk("sub_cin_ignored", res, 18'h10002);
    @(posedge clk); #1;
    idx = 0; first = -1; last = -1; extra = 0;
    set_vec(0);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(posedge clk); #1;
      if (cyc + 1 < 8) set_vec(cyc + 1);
      else in_valid = 1'b0;
      if (out_valid && idx < 8) begin
        chk($sformatf("stream%0d", idx), res, ve[idx]);
        if (first < 0) first = cyc;
        last = cyc;
        idx++;
      end else if (out_valid) extra++;
    end
    chk("stream_count", 18'(idx + extra), 18'd8);
    chk("stream_gapless", 18'(last - first), 18'd7);
    out_ready = 1'b0;
    p = 0;
    for (int i = 0; i < 6; i++) begin
      set_vec(p);
      in_valid = 1'b1;
      #1;
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) p++;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 18'(p), 18'd4);
    chk("bp_in_ready", 18'(in_ready), 18'd0);
    chk("bp_out_valid", 18'(out_valid), 18'd1);
    chk("bp_head", res, ve[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_hold", res, ve[0]);
    chk("bp_in_ready_hold", 18'(in_ready), 18'd0);
    out_ready = 1'b1;
    #1;
    chk("full_pass_ready", 18'(in_ready), 18'd1);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain_valid%0d", j), 18'(out_valid), 18'd1);
      chk($sformatf("drain%0d", j), res, ve[j]);
      @(posedge clk); #1;
    end
    chk("drain_empty", 18'(out_valid), 18'd0);
    for (int i = 0; i < 3; i++) send(va[i], vb[i], vc[i], vs[i]);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 18'(in_ready), 18'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) n++;
      @(posedge clk); #1;
    end
    chk("rst_flush", 18'(n), 18'd0);
    chk("rst_ready_after", 18'(in_ready), 18'd1);
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 20000 && (sent < 2000 || q.size() > 0); cyc++) begin
      in_valid = sent < 2000 && $urandom_range(0, 3) != 0;
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      acc = in_valid && in_ready;
      con = out_valid && out_ready;
      if (con) begin
        chk("soak", res, q.size() > 0 ? q.pop_front() : 18'hxxxxx);
        got++;
      end
      if (acc) begin
        q.push_back(model(a, b, cin, sub));
        sent++;
      end
      @(posedge clk); #1;
    end
    chk("soak_sent", 18'(sent), 18'd2000);
    chk("soak_delivered", 18'(got), 18'd2000);
    chk("soak_leftover", 18'(q.size()), 18'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
